apu_dsp_mult_pipe: RTL and testbench

APU_DSP_MULT_PIPE -- requirements
Module: apu_dsp_mult_pipe

---
 rtl/riscv_defines_apu.sv | 89 ++++++++
 rtl/apu_dsp_mult_stage.sv | 37 +++
 rtl/apu_dsp_mult_pipe.sv | 89 ++++++++
 tb/tb_apu_dsp_mult_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines_apu.sv
// Shared encodings, stage payload and arithmetic helpers for the APU DSP multiplier.
// Operations are evaluated at a 36-bit signed width. MAC32 and MSU32 use the low
// 36 bits of the product. Results wrap to 32 bits unless saturation is requested.
package riscv_defines_apu;

  localparam logic [2:0] MUL_MAC32 = 3'd0;
  localparam logic [2:0] MUL_MSU32 = 3'd1;
  localparam logic [2:0] MUL_DOT8  = 3'd2;
  localparam logic [2:0] MUL_DOT16 = 3'd3;

  // Guard bits above 32 so saturation can see overflow before the clip.
  localparam int ACC_W     = 36;
  // Widest tag a pipeline instance may carry; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [ACC_W-1:0]     result;
    logic [TAG_MAX_W-1:0] tag;
    logic                 sat;
  } stage_payload_t;

  // Full-precision result at ACC_W bits; the low 32 bits equal the wrapped result.
  function automatic logic [ACC_W-1:0] mult_compute(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [1:0]  dsgn
  );
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] dot8;
    logic signed [ACC_W-1:0] dot16;
    logic signed [ACC_W-1:0] ea;
    logic signed [ACC_W-1:0] eb;
    logic signed [63:0]      a64;
    logic signed [63:0]      b64;
    logic signed [63:0]      full;
    logic [8:0]              a8;
    logic [8:0]              b8;
    logic [16:0]             a16;
    logic [16:0]             b16;
    logic [ACC_W-1:0]        res;

    acc  = {{(ACC_W-32){c[31]}}, c};
    a64  = {{32{a[31]}}, a};
    b64  = {{32{b[31]}}, b};
    full = a64 * b64;
    prod = full[ACC_W-1:0];

    dot8 = '0;
    for (int i = 0; i < 4; i++) begin
      a8   = {dsgn[1] & a[8*i+7], a[8*i +: 8]};
      b8   = {dsgn[0] & b[8*i+7], b[8*i +: 8]};
      ea   = {{(ACC_W-9){a8[8]}}, a8};
      eb   = {{(ACC_W-9){b8[8]}}, b8};
      dot8 = dot8 + ea * eb;
    end

    dot16 = '0;
    for (int i = 0; i < 2; i++) begin
      a16   = {dsgn[1] & a[16*i+15], a[16*i +: 16]};
      b16   = {dsgn[0] & b[16*i+15], b[16*i +: 16]};
      ea    = {{(ACC_W-17){a16[16]}}, a16};
      eb    = {{(ACC_W-17){b16[16]}}, b16};
      dot16 = dot16 + ea * eb;
    end

    case (op)
      MUL_MAC32: res = acc + prod;
      MUL_MSU32: res = acc - prod;
      MUL_DOT8:  res = acc + dot8;
      MUL_DOT16: res = acc + dot16;
      default:   res = '0;
    endcase
    return res;
  endfunction

  // Clip to the signed 32-bit range when saturating; otherwise keep the low 32 bits.
  function automatic logic [31:0] sat_clip(input logic [ACC_W-1:0] r, input logic sat);
    logic in_range;
    in_range = (&r[ACC_W-1:31]) || (~|r[ACC_W-1:31]);
    if (sat && !in_range) begin
      return r[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/apu_dsp_mult_stage.sv
// One valid/ready register slice carrying a stage payload.
// Latency is 1 cycle. Throughput is full, with no bubble when the slice drains and refills in the same cycle.
// The slice accepts new data when it is empty or its contents are leaving, so in_ready follows out_ready combinationally.
module apu_dsp_mult_stage
  import riscv_defines_apu::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  stage_payload_t in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output stage_payload_t out_data
);

  assign in_ready = !out_valid || out_ready;

  // Hold contents while stalled; load on accept; flush only drops the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/apu_dsp_mult_pipe.sv
// Pipelined MAC/MSU/DOT8/DOT16 multiplier. The optional sat_i input exists only when APU_DSP_MULT_SAT_EN is defined.
// Latency is NUM_STAGES cycles with one operation per cycle. Arithmetic runs before stage 0 and the clip after the last stage.
// ready_o is high when any stage downstream has room or ready_i is high. A stalled output holds steady.
module apu_dsp_mult_pipe
  import riscv_defines_apu::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           operator_i,
  input  logic [31:0]          op_a_i,
  input  logic [31:0]          op_b_i,
  input  logic [31:0]          op_c_i,
  input  logic [1:0]           dot_signed_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
`ifdef APU_DSP_MULT_SAT_EN
  input  logic                 sat_i,
`endif
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          result_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  // vld[0] is the input request, and vld[k+1] shows that stage k holds an operation.
  logic [NUM_STAGES:0]   vld;
  logic [NUM_STAGES-1:0] down_rdy;
  logic [NUM_STAGES-1:0] up_rdy;
  stage_payload_t        pay [NUM_STAGES+1];
  stage_payload_t        in_pay;
  stage_payload_t        out_pay;

  // Build the stage-0 payload from the incoming operation.
  always_comb begin
    in_pay        = '0;
    in_pay.result = mult_compute(operator_i, op_a_i, op_b_i, op_c_i, dot_signed_i);
    in_pay.tag    = TAG_MAX_W'(tag_i);
`ifdef APU_DSP_MULT_SAT_EN
    in_pay.sat    = sat_i;
`endif
  end

  assign vld[0] = valid_i;
  assign pay[0] = in_pay;

  // Derive each stage's downstream ready from the valid bits, not from a ready chain.
  // Stage k may advance unless every later stage is occupied and the output is stalled.
  always_comb begin
    logic full;
    down_rdy = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      full = 1'b1;
      for (int j = k + 2; j <= NUM_STAGES; j++) begin
        full = full & vld[j];
      end
      down_rdy[k] = ready_i | ~full;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    apu_dsp_mult_stage u_stage (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .flush     (flush_i),
      .in_valid  (vld[k]),
      .in_ready  (up_rdy[k]),
      .in_data   (pay[k]),
      .out_valid (vld[k+1]),
      .out_ready (down_rdy[k]),
      .out_data  (pay[k+1])
    );
  end

  assign ready_o  = up_rdy[0];
  assign out_pay  = pay[NUM_STAGES];
  assign valid_o  = vld[NUM_STAGES];
  assign result_o = sat_clip(out_pay.result, out_pay.sat);
  assign tag_o    = out_pay.tag[TAG_WIDTH-1:0];

  // The in_ready outputs of later stages duplicate down_rdy, and the high tag bits are always zero.
  logic unused_bits;
  assign unused_bits = ^{up_rdy, out_pay.tag};

endmodule

// File: tb/tb_apu_dsp_mult_pipe.sv
// Directed bench for apu_dsp_mult_pipe at NUM_STAGES=2 and TAG_WIDTH=5.
module tb_apu_dsp_mult_pipe;
  import riscv_defines_apu::*;

  localparam int NS = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [1:0]  dsgn;
  logic [4:0]  tag_in;
  logic        sat;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int n_cmp;
  int n_bad;

  int          sent;
  int          got;
  int          occ;
  logic        pv;
  logic        pr;
  logic [31:0] pres;
  logic [4:0]  ptag;
  logic        acc;
  logic        dlv;

  apu_dsp_mult_pipe #(.NUM_STAGES(NS), .TAG_WIDTH(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .valid_i      (valid_in),
    .ready_o      (ready_out),
    .operator_i   (op),
    .op_a_i       (a),
    .op_b_i       (b),
    .op_c_i       (c),
    .dot_signed_i (dsgn),
    .tag_i        (tag_in),
`ifdef APU_DSP_MULT_SAT_EN
    .sat_i        (sat),
`endif
    .valid_o      (valid_out),
    .ready_i      (ready_in),
    .result_o     (result),
    .tag_o        (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ic, input logic [1:0] ds, input logic [4:0] t);
    op = o; a = ia; b = ib; c = ic; dsgn = ds; tag_in = t;
  endtask

  // Issue one op just after a rising edge, then check the exact NUM_STAGES latency.
  task automatic run_one(input string name, input logic [2:0] o, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] ic, input logic [1:0] ds,
                         input logic [4:0] t, input logic [31:0] exp_res);
    drive(o, ia, ib, ic, ds, t);
    valid_in = 1'b1;
    ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    chk({name, "_early"}, 32'(valid_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_vld"}, 32'(valid_out), 32'd1);
    chk({name, "_res"}, result, exp_res);
    chk({name, "_tag"}, 32'(tag_out), 32'(t));
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1; sat = 1'b0;
    drive(3'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'd0);

    // Check reset state and ready after release.
    #2;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ready_out), 32'd1);
    @(posedge clk); #1;

    // Run single operations with hand-computed results.
    run_one("mac_basic", MUL_MAC32, 32'd3, 32'hFFFF_FFFC, 32'd100, 2'b00, 5'd7, 32'd88);
    run_one("msu_wrap", MUL_MSU32, 32'h0001_0000, 32'h0001_0000, 32'd5, 2'b00, 5'd1, 32'd5);
    run_one("msu_small", MUL_MSU32, 32'd2, 32'd3, 32'd10, 2'b00, 5'd2, 32'd4);
    run_one("mac_neg1sq", MUL_MAC32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b00, 5'd3, 32'd1);
    run_one("dot8_basic", MUL_DOT8, 32'h0102_0304, 32'h0101_0101, 32'd0, 2'b00, 5'd4, 32'd10);
    run_one("dot8_ss", MUL_DOT8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b11, 5'd5, 32'd4);
    run_one("dot8_uu", MUL_DOT8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b00, 5'd6, 32'h0003_F804);
    run_one("dot8_su", MUL_DOT8, 32'hFF00_0000, 32'h0200_0000, 32'd0, 2'b10, 5'd8, 32'hFFFF_FFFE);
    run_one("dot8_us", MUL_DOT8, 32'hFF00_0000, 32'h0200_0000, 32'd0, 2'b01, 5'd9, 32'h0000_01FE);
    run_one("dot16_uu", MUL_DOT16, 32'h0002_0003, 32'h0004_0005, 32'd1, 2'b00, 5'd10, 32'd24);
    run_one("dot16_ss", MUL_DOT16, 32'hFFFF_0002, 32'h0003_0004, 32'd10, 2'b11, 5'd11, 32'd15);
    run_one("bad_op", 3'd5, 32'd7, 32'd9, 32'd123, 2'b00, 5'd31, 32'd0);

`ifdef APU_DSP_MULT_SAT_EN
    // Check saturating and wrapping behaviour.
    sat = 1'b1;
    run_one("sat_pos", MUL_DOT16, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 2'b11, 5'd12, 32'h7FFF_FFFF);
    run_one("sat_neg", MUL_DOT16, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 2'b11, 5'd13, 32'h8000_0000);
    sat = 1'b0;
    run_one("sat_off", MUL_DOT16, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 2'b11, 5'd14, 32'hFFFF_FFFF);
`endif

    // Send a stream of 8 ops with ready_i low in cycles 3-6.
    sent = 0; got = 0; occ = 0; pv = 1'b0; pr = 1'b1; pres = '0; ptag = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      ready_in = !(cyc >= 3 && cyc <= 6);
      valid_in = (sent < 8);
      drive(MUL_MAC32, 32'(sent + 1), 32'd10, 32'(sent), 2'b00, 5'(sent + 8));
      @(negedge clk);
      chk("stream_rdy", 32'(ready_out), (occ == NS && !ready_in) ? 32'd0 : 32'd1);
      if (pv && !pr) begin
        chk("stall_vld", 32'(valid_out), 32'd1);
        chk("stall_res", result, pres);
        chk("stall_tag", 32'(tag_out), 32'(ptag));
      end
      acc = valid_in && ready_out;
      dlv = valid_out && ready_in;
      if (dlv) begin
        chk("stream_res", result, 32'(11 * got + 10));
        chk("stream_tag", 32'(tag_out), 32'(got + 8));
        got++;
      end
      pv = valid_out; pr = ready_in; pres = result; ptag = tag_out;
      occ = occ + int'(acc) - int'(dlv);
      if (acc) sent++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    chk("stream_count", 32'(got), 32'd8);

    // Flush two ops in flight and one presented; none may emerge.
    ready_in = 1'b0;
    drive(MUL_MAC32, 32'd1, 32'd1, 32'd1, 2'b00, 5'd20);
    valid_in = 1'b1;
    @(posedge clk); #1;
    drive(MUL_MAC32, 32'd2, 32'd2, 32'd2, 2'b00, 5'd21);
    @(posedge clk); #1;
    drive(MUL_MAC32, 32'd3, 32'd3, 32'd3, 2'b00, 5'd22);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_none", 32'(valid_out), 32'd0);
      @(posedge clk); #1;
    end
    run_one("after_flush", MUL_MAC32, 32'd6, 32'd7, 32'd1, 2'b00, 5'd23, 32'd43);

    // Assert reset while an op waits at the stalled output.
    ready_in = 1'b0;
    drive(MUL_MAC32, 32'd5, 32'd5, 32'd0, 2'b00, 5'd24);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_vld", 32'(valid_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(valid_out), 32'd0);
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_tag", 32'(tag_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(ready_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_none", 32'(valid_out), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
